// File: rtl/hkspi_pkg.sv
// Shared op-codes and FSM state encoding for the housekeeping SPI slave.
package hkspi_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_RW  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/hkspi_sync_edge.sv
// N-stage synchronizer for one pad input, with level, rise and fall outputs.
module hkspi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clock,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the raw input through the synchronizer, keep one extra flop for edges.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/hkspi_slave_engine.sv
// Housekeeping SPI slave: decodes cmd/addr/data bytes and drives a register port.
module hkspi_slave_engine
  import hkspi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              spi_sck,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  logic w_sck_rise, w_sck_fall, w_unused_sck_level;
  logic w_csb_level, w_csb_rise, w_csb_fall;
  logic w_sdi, w_unused_sdi_rise, w_unused_sdi_fall;

  hkspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clock(clock), .i_resetn(resetn), .i_d(spi_sck),
    .o_level(w_unused_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  // CSB idles high so reset does not look like an active transaction.
  hkspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
    .i_clock(clock), .i_resetn(resetn), .i_d(spi_csb),
    .o_level(w_csb_level), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
  );

  hkspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .i_clock(clock), .i_resetn(resetn), .i_d(spi_sdi),
    .o_level(w_sdi), .o_rise(w_unused_sdi_rise), .o_fall(w_unused_sdi_fall)
  );

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_bitcnt;
  logic [6:0]  r_rx;
  logic [1:0]  r_op;
  logic [2:0]  r_left;
  logic        r_counted;
  logic        r_more;
  logic        r_we_pend;
  logic        r_post;
  logic        r_re_d;
  logic [7:0]  r_tx;
  logic        r_oe;

  logic        w_bit;
  logic        w_byte_done;
  logic [7:0]  w_byte;
  logic        w_last_data;
  logic        w_op_rd;
  logic        w_op_wr;

  assign w_bit       = w_sck_rise &&
                       (r_state == ST_CMD || r_state == ST_ADDR || r_state == ST_DATA);
  assign w_byte_done = w_bit && (r_bitcnt == 3'd7);
  assign w_byte      = {r_rx, w_sdi};
  assign w_last_data = r_counted && (r_left == 3'd1);
  assign w_op_rd     = (r_op == OP_RD) || (r_op == OP_RW);
  assign w_op_wr     = (r_op == OP_WR) || (r_op == OP_RW);

  assign busy       = ~w_csb_level;
  assign spi_sdo    = r_tx[7];
  assign spi_sdo_oe = r_oe;

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode; a CSB rise always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (w_csb_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_csb_fall) w_state_nxt = ST_CMD;
        ST_CMD:  if (w_byte_done)
                   w_state_nxt = (w_byte[7:6] == OP_NOP) ? ST_DONE : ST_ADDR;
        ST_ADDR: if (w_byte_done) w_state_nxt = ST_DATA;
        ST_DATA: if (w_byte_done && w_last_data) w_state_nxt = ST_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Bit shifting, register-port strobes and SDO shifter.
  // For read-then-write the write strobe goes first on the byte's address;
  // the increment and the read for the next byte follow one clock later.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_bitcnt  <= '0;
      r_rx      <= '0;
      r_op      <= '0;
      r_left    <= '0;
      r_counted <= 1'b0;
      r_more    <= 1'b0;
      r_we_pend <= 1'b0;
      r_post    <= 1'b0;
      r_re_d    <= 1'b0;
      r_tx      <= '0;
      r_oe      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      r_re_d <= reg_re;

      if (w_csb_fall && r_state == ST_IDLE) begin
        r_bitcnt <= '0;
        r_rx     <= '0;
      end else if (w_bit) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_rx     <= w_byte[6:0];
      end

      if (w_byte_done) begin
        case (r_state)
          ST_CMD: begin
            r_op      <= w_byte[7:6];
            r_left    <= w_byte[5:3];
            r_counted <= (w_byte[5:3] != 3'd0);
          end
          ST_ADDR: begin
            reg_addr <= ADDR_W'(w_byte);
            if (w_op_rd) reg_re <= 1'b1;
          end
          ST_DATA: begin
            if (r_counted) r_left <= r_left - 3'd1;
            if (w_op_wr) begin
              reg_wdata <= w_byte;
              r_we_pend <= 1'b1;
              r_more    <= !w_last_data;
            end else begin
              reg_addr <= reg_addr + ADDR_W'(1);
              reg_re   <= !w_last_data;
            end
          end
          default: ;
        endcase
      end

      if (r_we_pend) begin
        reg_we    <= 1'b1;
        r_we_pend <= 1'b0;
        r_post    <= 1'b1;
      end

      if (r_post) begin
        r_post   <= 1'b0;
        reg_addr <= reg_addr + ADDR_W'(1);
        if (w_op_rd && r_more) reg_re <= 1'b1;
      end

      // Load is only accepted in DATA; the fall that ends a byte does not shift.
      if (r_re_d && r_state == ST_DATA) begin
        r_tx <= reg_rdata;
        r_oe <= 1'b1;
      end else if (w_sck_fall && r_state == ST_DATA && r_bitcnt != 3'd0) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end

      if (w_csb_rise || (w_byte_done && r_state == ST_DATA && w_last_data))
        r_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hkspi_slave_engine.sv
// Randomized scoreboard bench for hkspi_slave_engine.
module tb_hkspi_slave_engine;

  localparam int unsigned HALF = 7;

  typedef struct {
    logic       chk;
    logic       oe;
    logic [7:0] d;
  } bexp_t;

  typedef struct {
    logic [7:0] d;
    logic       oe_and;
    logic       oe_or;
  } bobs_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sck = 1'b0;
  logic       csb = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo, oe, we, re, busy;
  logic [7:0] addr, wdata;
  logic [7:0] rdata = 8'h00;

  logic [7:0] mem [256];
  logic [7:0] mdl [256];
  logic       mem_init = 1'b0;

  int checks = 0;
  int errors = 0;

  bexp_t      q_bexp [$];
  bobs_t      q_bobs [$];
  logic [7:0] q_re   [$];
  logic [15:0] q_wr  [$];
  logic [7:0] txd    [$];

  always #5 clk = ~clk;

  hkspi_slave_engine #(.SYNC_STAGES(2), .ADDR_W(8)) dut (
    .clock(clk), .resetn(resetn),
    .spi_sck(sck), .spi_csb(csb), .spi_sdi(sdi),
    .spi_sdo(sdo), .spi_sdo_oe(oe),
    .reg_addr(addr), .reg_wdata(wdata), .reg_we(we), .reg_re(re),
    .reg_rdata(rdata), .busy(busy)
  );

  // Register bank: read data one clock after the read strobe.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= mdl[i];
      mem_init <= 1'b1;
    end else begin
      if (re) rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes or a byte is observed.
  always @(negedge clk) begin : mon
    logic [15:0] w;
    logic [7:0]  a;
    bobs_t       o;
    bexp_t       e;
    if (we || re) chk("we_re_exclusive", {31'd0, we & re}, 32'd0);
    if (we) begin
      checks++;
      if (q_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we actual addr=%0h data=%0h required none", addr, wdata);
      end else begin
        w = q_wr.pop_front();
        chk("we_addr", {24'd0, addr}, {24'd0, w[15:8]});
        chk("we_data", {24'd0, wdata}, {24'd0, w[7:0]});
      end
    end
    if (re) begin
      checks++;
      if (q_re.size() == 0) begin
        errors++;
        $display("FAIL unexpected_re actual addr=%0h required none", addr);
      end else begin
        a = q_re.pop_front();
        chk("re_addr", {24'd0, addr}, {24'd0, a});
      end
    end
    while (q_bobs.size() > 0) begin
      o = q_bobs.pop_front();
      if (q_bexp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%0h required none", o.d);
      end else begin
        e = q_bexp.pop_front();
        if (e.oe) chk("sdo_oe_high", {31'd0, o.oe_and}, 32'd1);
        else      chk("sdo_oe_low",  {31'd0, o.oe_or},  32'd0);
        if (e.chk) chk("sdo_byte", {24'd0, o.d}, {24'd0, e.d});
      end
    end
  end

  // Transaction-level reference: what the register bank and SDO should see.
  function automatic void model_txn(input logic [7:0] cmd, input logic [7:0] a0,
                                    input int unsigned ndata);
    logic [1:0] op;
    int unsigned n;
    logic [7:0] a;
    bexp_t nop_b;
    bexp_t rd_b;
    op = cmd[7:6];
    n  = int'(cmd[5:3]);
    a  = a0;
    nop_b.chk = 1'b0; nop_b.oe = 1'b0; nop_b.d = 8'h00;
    q_bexp.push_back(nop_b);
    q_bexp.push_back(nop_b);
    if (op == 2'b00) begin
      for (int unsigned i = 0; i < ndata; i++) q_bexp.push_back(nop_b);
      return;
    end
    if (op[0]) q_re.push_back(a);
    for (int unsigned i = 0; i < ndata; i++) begin
      if (n != 0 && i >= n) begin
        q_bexp.push_back(nop_b);
      end else begin
        if (op[0]) begin
          rd_b.chk = 1'b1; rd_b.oe = 1'b1; rd_b.d = mdl[a];
          q_bexp.push_back(rd_b);
        end else begin
          q_bexp.push_back(nop_b);
        end
        if (op[1]) begin
          q_wr.push_back({a, txd[i]});
          mdl[a] = txd[i];
        end
        a = a + 8'd1;
        if (op[0] && !(n != 0 && i == n - 1)) q_re.push_back(a);
      end
    end
  endfunction

  task automatic spi_byte(input logic [7:0] b, input int unsigned nbits, output bobs_t o);
    o.d = 8'h00; o.oe_and = 1'b1; o.oe_or = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) begin
      sdi = b[7-i];
      repeat (HALF) @(posedge clk);
      #1;
      o.d    = {o.d[6:0], sdo};
      o.oe_and = o.oe_and & oe;
      o.oe_or  = o.oe_or | oe;
      sck = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      sck = 1'b0;
    end
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input logic [7:0] a,
                         input int unsigned ndata, input int unsigned partial,
                         input logic rst_mid);
    bobs_t o;
    model_txn(cmd, a, ndata);
    csb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    spi_byte(cmd, 8, o); q_bobs.push_back(o);
    spi_byte(a, 8, o);   q_bobs.push_back(o);
    for (int unsigned i = 0; i < ndata; i++) begin
      spi_byte(txd[i], 8, o);
      q_bobs.push_back(o);
    end
    if (partial != 0) spi_byte(txd[ndata], partial, o);
    if (rst_mid) begin
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_mid_outputs", {11'd0, sdo, oe, addr, wdata, we, re, busy}, 32'd0);
      csb = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      resetn = 1'b1;
    end else begin
      repeat (HALF) @(posedge clk);
      #1;
      csb = 1'b1;
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] c, a;
    int unsigned nd, pb;
    int mism;
    for (int i = 0; i < 256; i++) mdl[i] = 8'($urandom);
    mdl[3] = 8'h10;
    mdl[5] = 8'h3C;

    repeat (4) @(posedge clk);
    #1;
    chk("reset_outputs", {11'd0, sdo, oe, addr, wdata, we, re, busy}, 32'd0);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    txd = {8'h00};
    spi_txn(8'h40, 8'h03, 1, 0, 1'b0);

    txd.delete();
    for (int i = 0; i < 19; i++) txd.push_back(8'($urandom));
    spi_txn(8'h40, 8'h00, 19, 0, 1'b0);

    txd = {8'h01};
    spi_txn(8'h80, 8'h0B, 1, 0, 1'b0);

    txd = {8'hAA, 8'h55, 8'h77};
    spi_txn(8'h90, 8'hFE, 3, 0, 1'b0);

    txd = {8'hA5};
    spi_txn(8'hC0, 8'h05, 1, 0, 1'b0);

    txd = {8'hF0};
    spi_txn(8'h80, 8'h30, 0, 4, 1'b0);

    txd = {8'h5A, 8'h11};
    spi_txn(8'h00, 8'h44, 2, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      c  = {2'($urandom), 3'($urandom_range(0, 3)), 3'($urandom)};
      a  = 8'($urandom);
      nd = $urandom_range(0, 5);
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      txd.delete();
      for (int unsigned i = 0; i <= nd; i++) txd.push_back(8'($urandom));
      spi_txn(c, a, nd, pb, 1'b0);
    end

    txd = {8'h66, 8'h99};
    spi_txn(8'h80, 8'h21, 1, 3, 1'b1);

    txd = {8'h00, 8'h00};
    spi_txn(8'h48, 8'hFF, 2, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_writes", q_wr.size(), 32'd0);
    chk("pending_reads", q_re.size(), 32'd0);
    chk("pending_bytes", q_bexp.size(), 32'd0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mdl[i]) mism++;
    chk("regbank_contents", mism, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
